// File: rtl/mant_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : mant_mul_sched
// Description : Shared iterative unsigned mantissa multiplier with a
//               two-requester round-robin front end. One radix-4 shift-add
//               datapath is time-shared between the FP multiply path and a
//               second client (divider/sqrt normaliser). Each operation takes
//               WIDTH/2 RUN cycles and returns the full 2*WIDTH-bit product
//               together with the id of the requester that issued it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1        clock, rising edge
//   rstn        in   1        asynchronous active-low reset
//   req0_valid  in   1        requester 0 has an operand pair
//   req0_ready  out  1        requester 0 accepted when valid&ready
//   req0_a      in   WIDTH    requester 0 multiplicand
//   req0_b      in   WIDTH    requester 0 multiplier
//   req1_valid  in   1        requester 1 has an operand pair
//   req1_ready  out  1        requester 1 accepted when valid&ready
//   req1_a      in   WIDTH    requester 1 multiplicand
//   req1_b      in   WIDTH    requester 1 multiplier
//   res_valid   out  1        product available
//   res_ready   in   1        consumer takes product when valid&ready
//   res_data    out  2*WIDTH  unsigned product a*b
//   res_id      out  1        id of the requester that issued the operation
//   busy        out  1        high while an operation is in RUN or DONE
// ============================================================================
module mant_mul_sched #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_id,
  output logic                 busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_HALF  = WIDTH / 2;
  localparam int c_CNT_W = $clog2(c_HALF + 1);

  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(c_HALF - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic                 r_ptr;       // 0: req0 has priority, 1: req1 has priority
  logic [WIDTH-1:0]     r_a;         // captured multiplicand
  logic [WIDTH-1:0]     r_b_sh;      // captured multiplier, consumed 2 bits per step
  logic                 r_id;        // id of the operation in flight
  logic [2*WIDTH-1:0]   r_acc;       // running sum of partial products
  logic [c_CNT_W-1:0]   r_cnt;       // radix-4 step index
  logic [2*WIDTH-1:0]   r_res_data;  // product presented to the consumer
  logic                 r_res_id;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic             w_idle;
  logic             w_any_valid;
  logic             w_gnt_id;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  assign w_idle      = (r_state == c_IDLE);
  assign w_any_valid = req0_valid | req1_valid;

  // Pointer side wins when it is valid; otherwise the other side gets it.
  // Only meaningful while w_any_valid is high.
  assign w_gnt_id = r_ptr ? req1_valid : ~req0_valid;

  assign req0_ready = w_idle & w_any_valid & ~w_gnt_id;
  assign req1_ready = w_idle & w_any_valid &  w_gnt_id;

  // Ready is only ever raised towards a valid requester, so any ready implies
  // a handshake on this edge.
  assign w_accept = w_idle & w_any_valid;

  assign w_sel_a = w_gnt_id ? req1_a : req0_a;
  assign w_sel_b = w_gnt_id ? req1_b : req0_b;

  // --------------------------------------------------------------------------
  // Radix-4 partial product: a * b[1:0], at most 3*a, fits in WIDTH+2 bits
  // --------------------------------------------------------------------------
  logic [WIDTH+1:0]   w_a_x1;
  logic [WIDTH+1:0]   w_a_x2;
  logic [WIDTH+1:0]   w_pp;
  logic [2*WIDTH-1:0] w_pp_wide;
  logic [2*WIDTH-1:0] w_pp_shift;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_a_x1 = {2'b00, r_a};
  assign w_a_x2 = {1'b0, r_a, 1'b0};

  always_comb begin
    w_pp = '0;
    case (r_b_sh[1:0])
      2'd0:    w_pp = '0;
      2'd1:    w_pp = w_a_x1;
      2'd2:    w_pp = w_a_x2;
      default: w_pp = w_a_x1 + w_a_x2;
    endcase
  end

  assign w_pp_wide  = {{(WIDTH-2){1'b0}}, w_pp};
  // Weight of the current digit is 4^cnt, i.e. a left shift by 2*cnt.
  assign w_pp_shift = w_pp_wide << {r_cnt, 1'b0};
  // The final sum equals a*b < 2^(2*WIDTH), so no carry out is lost.
  assign w_acc_next = r_acc + w_pp_shift;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= c_IDLE;
      r_ptr      <= 1'b0;
      r_a        <= '0;
      r_b_sh     <= '0;
      r_id       <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_res_data <= '0;
      r_res_id   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_a     <= w_sel_a;
            r_b_sh  <= w_sel_b;
            r_id    <= w_gnt_id;
            r_acc   <= '0;
            r_cnt   <= '0;
            // Next time, the requester that lost this round goes first.
            r_ptr   <= ~w_gnt_id;
            r_state <= c_RUN;
          end
        end

        c_RUN: begin
          r_acc  <= w_acc_next;
          r_b_sh <= r_b_sh >> 2;
          r_cnt  <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_LAST_STEP) begin
            // Latch the product separately so it stays put through DONE and
            // after the handshake, independent of the working accumulator.
            r_res_data <= w_acc_next;
            r_res_id   <= r_id;
            r_state    <= c_DONE;
          end
        end

        c_DONE: begin
          // Ready is low in DONE, so returning to IDLE forces a one-cycle
          // bubble before the next accept.
          if (res_ready) begin
            r_state <= c_IDLE;
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign res_valid = (r_state == c_DONE);
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire
